// File: rtl/wb_arb_pkg.sv
// Shared types and widths for the N-master Wishbone arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state encoding, Wishbone select/address/data widths.
package wb_arb_pkg;

  localparam int SEL_W = 4;
  localparam int ADR_W = 32;
  localparam int DAT_W = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wb_arb_rr_picker.sv
// Combinational winner search over a request vector (round-robin or fixed priority).
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides when to register the result.
// Ports: req_i request vector, last_i previous winner, rr_mode_i 1=round-robin 0=fixed,
//        idx_o winning index, vld_o high when any request is present.
module wb_arb_rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  input  logic          rr_mode_i,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  logic [IW-1:0] cand;

  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    if (rr_mode_i) begin
      // Walk from the farthest offset to the nearest so that the first
      // requester after last_i is the one left in idx_o.
      for (int off = N; off >= 1; off--) begin
        cand = IW'((int'(last_i) + off) % N);
        if (req_i[cand]) begin
          idx_o = cand;
          vld_o = 1'b1;
        end
      end
    end else begin
      // Highest index first so index 0 overrides everything.
      for (int k = N - 1; k >= 0; k--) begin
        if (req_i[IW'(k)]) begin
          idx_o = IW'(k);
          vld_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_n_masters.sv
// Shares one Wishbone slave between MASTER_COUNT masters (round-robin or fixed priority).
// Latency: grant one cycle after cyc is seen in IDLE; owner signals pass through combinationally.
// Backpressure: the owner keeps the bus while it holds cyc; others wait for IDLE (optional stall timeout).
// Ports: clk/rst (sync, active-high); i_m_* packed per-master inputs; o_m_ack/o_m_err per-master,
//        o_m_dat/o_m_int broadcast; o_s_* slave-side mirror of the owner; i_s_* slave responses;
//        o_grant one-hot owner. Define WB_ARB_TIMEOUT_EN to enable the stalled-strobe timeout.
import wb_arb_pkg::*;

module wb_arbiter_n_masters #(
  parameter int MASTER_COUNT = 4,
  parameter int ROUND_ROBIN  = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MASTER_COUNT-1:0]   i_m_we,
  input  logic [MASTER_COUNT-1:0]   i_m_cyc,
  input  logic [MASTER_COUNT-1:0]   i_m_stb,
  input  logic [4*MASTER_COUNT-1:0] i_m_sel,
  input  logic [32*MASTER_COUNT-1:0] i_m_adr,
  input  logic [32*MASTER_COUNT-1:0] i_m_dat,
  output logic [MASTER_COUNT-1:0]   o_m_ack,
  output logic [MASTER_COUNT-1:0]   o_m_int,
  output logic [MASTER_COUNT-1:0]   o_m_err,
  output logic [31:0]               o_m_dat,
  output logic                      o_s_we,
  output logic                      o_s_stb,
  output logic                      o_s_cyc,
  output logic [3:0]                o_s_sel,
  output logic [31:0]               o_s_adr,
  output logic [31:0]               o_s_dat,
  input  logic [31:0]               i_s_dat,
  input  logic                      i_s_ack,
  input  logic                      i_s_int,
  output logic [MASTER_COUNT-1:0]   o_grant
);

  localparam int IW = $clog2(MASTER_COUNT);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] pick_idx;
  logic          pick_vld;
  logic          to_fire;

  wb_arb_rr_picker #(
    .N  (MASTER_COUNT),
    .IW (IW)
  ) u_picker (
    .req_i     (i_m_cyc),
    .last_i    (last_q),
    .rr_mode_i (ROUND_ROBIN != 0),
    .idx_o     (pick_idx),
    .vld_o     (pick_vld)
  );

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  // Counts consecutive stalled strobe cycles of the current owner; an ack or
  // leaving GRANT restarts it. to_fire marks the cycle the limit is reached.
  always_comb begin
    cnt_d   = cnt_q;
    to_fire = 1'b0;
    if (state_q == ST_GRANT) begin
      if (i_s_ack) begin
        cnt_d = '0;
      end else if (o_s_stb) begin
        cnt_d   = cnt_q + 16'd1;
        to_fire = (cnt_q == 16'(TIMEOUT - 1));
      end
    end else begin
      cnt_d = '0;
    end
    if (to_fire) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign to_fire        = 1'b0;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= IW'(MASTER_COUNT - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_GRANT;
          owner_d = pick_idx;
          last_d  = pick_idx;
        end
      end
      ST_GRANT: begin
        // An ack still in flight keeps the grant even if cyc already dropped.
        if (to_fire || (!i_m_cyc[owner_q] && !i_s_ack)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_grant = '0;
    o_m_ack = '0;
    o_m_err = '0;
    o_s_we  = 1'b0;
    o_s_stb = 1'b0;
    o_s_cyc = 1'b0;
    o_s_sel = '0;
    o_s_adr = '0;
    o_s_dat = '0;
    if (state_q == ST_GRANT) begin
      o_grant[owner_q] = 1'b1;
      o_m_ack[owner_q] = i_s_ack;
      o_m_err[owner_q] = to_fire;
      o_s_we           = i_m_we[owner_q];
      o_s_stb          = i_m_stb[owner_q];
      o_s_cyc          = i_m_cyc[owner_q];
      o_s_sel          = i_m_sel[int'(owner_q)*SEL_W +: SEL_W];
      o_s_adr          = i_m_adr[int'(owner_q)*ADR_W +: ADR_W];
      o_s_dat          = i_m_dat[int'(owner_q)*DAT_W +: DAT_W];
    end
  end

  assign o_m_dat = i_s_dat;
  assign o_m_int = {MASTER_COUNT{i_s_int}};

endmodule

// File: tb/tb_wb_arbiter_n_masters.sv
module tb_wb_arbiter_n_masters;

  localparam int N         = 4;
  localparam int TIMEOUT_P = 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   m_we = '0, m_cyc = '0, m_stb = '0;
  logic [15:0]  m_sel = '0;
  logic [127:0] m_adr = '0, m_dat = '0;
  logic [31:0]  s_dat = '0;
  logic         s_ack = 1'b0, s_int = 1'b0;

  logic [3:0]  rr_ack, rr_int, rr_err, rr_grant;
  logic [31:0] rr_mdat, rr_sadr, rr_sdat;
  logic        rr_swe, rr_sstb, rr_scyc;
  logic [3:0]  rr_ssel;
  logic [3:0]  fp_ack, fp_int, fp_err, fp_grant;
  logic [31:0] fp_mdat, fp_sadr, fp_sdat;
  logic        fp_swe, fp_sstb, fp_scyc;
  logic [3:0]  fp_ssel;

  int errors = 0;
  int checks = 0;

  // Reference model state, index 0 = round-robin instance, 1 = fixed priority.
  int m_owner[2];
  int m_last[2];
  int m_cnt[2];

  always #5 clk = ~clk;

  wb_arbiter_n_masters #(.MASTER_COUNT(N), .ROUND_ROBIN(1), .TIMEOUT(TIMEOUT_P)) dut_rr (
    .clk(clk), .rst(rst), .i_m_we(m_we), .i_m_cyc(m_cyc), .i_m_stb(m_stb),
    .i_m_sel(m_sel), .i_m_adr(m_adr), .i_m_dat(m_dat),
    .o_m_ack(rr_ack), .o_m_int(rr_int), .o_m_err(rr_err), .o_m_dat(rr_mdat),
    .o_s_we(rr_swe), .o_s_stb(rr_sstb), .o_s_cyc(rr_scyc), .o_s_sel(rr_ssel),
    .o_s_adr(rr_sadr), .o_s_dat(rr_sdat), .i_s_dat(s_dat), .i_s_ack(s_ack),
    .i_s_int(s_int), .o_grant(rr_grant));

  wb_arbiter_n_masters #(.MASTER_COUNT(N), .ROUND_ROBIN(0), .TIMEOUT(TIMEOUT_P)) dut_fp (
    .clk(clk), .rst(rst), .i_m_we(m_we), .i_m_cyc(m_cyc), .i_m_stb(m_stb),
    .i_m_sel(m_sel), .i_m_adr(m_adr), .i_m_dat(m_dat),
    .o_m_ack(fp_ack), .o_m_int(fp_int), .o_m_err(fp_err), .o_m_dat(fp_mdat),
    .o_s_we(fp_swe), .o_s_stb(fp_sstb), .o_s_cyc(fp_scyc), .o_s_sel(fp_ssel),
    .o_s_adr(fp_sadr), .o_s_dat(fp_sdat), .i_s_dat(s_dat), .i_s_ack(s_ack),
    .i_s_int(s_int), .o_grant(fp_grant));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner by the arbitration rules: round-robin scans upward from the
  // previous winner with wrap, fixed priority takes the lowest index.
  function automatic int pick(input int d, input logic [3:0] req);
    if (d == 0) begin
      for (int s = 1; s <= N; s++)
        if (req[(m_last[d] + s) % N]) return (m_last[d] + s) % N;
    end else begin
      for (int k = 0; k < N; k++)
        if (req[k]) return k;
    end
    return -1;
  endfunction

  function automatic bit timeout_fires(input int d);
    int o;
    o = m_owner[d];
    return TO_EN && (o >= 0) && m_stb[o] && !s_ack && (m_cnt[d] == TIMEOUT_P - 1);
  endfunction

  task automatic check_one(input int d, input logic [3:0] g, ack, err, irq,
                           input logic scyc, sstb, swe, input logic [3:0] ssel,
                           input logic [31:0] sadr, sdat, mdat);
    string p;
    int o;
    logic [3:0] eg, eack, eerr, esel;
    logic [31:0] eadr, edat;
    logic ecyc, estb, ewe;
    p = (d == 0) ? "rr" : "fp";
    o = m_owner[d];
    eg = '0; eack = '0; eerr = '0; esel = '0; eadr = '0; edat = '0;
    ecyc = 1'b0; estb = 1'b0; ewe = 1'b0;
    if (o >= 0) begin
      eg[o] = 1'b1;
      eack[o] = s_ack;
      eerr[o] = timeout_fires(d);
      ecyc = m_cyc[o]; estb = m_stb[o]; ewe = m_we[o];
      esel = m_sel[o*4 +: 4];
      eadr = m_adr[o*32 +: 32];
      edat = m_dat[o*32 +: 32];
    end
    chk({p, ".grant"}, 32'(g), 32'(eg));
    chk({p, ".m_ack"}, 32'(ack), 32'(eack));
    chk({p, ".m_err"}, 32'(err), 32'(eerr));
    chk({p, ".m_int"}, 32'(irq), {28'd0, {4{s_int}}});
    chk({p, ".m_dat"}, mdat, s_dat);
    chk({p, ".s_cyc"}, 32'(scyc), 32'(ecyc));
    chk({p, ".s_stb"}, 32'(sstb), 32'(estb));
    chk({p, ".s_we"},  32'(swe),  32'(ewe));
    chk({p, ".s_sel"}, 32'(ssel), 32'(esel));
    chk({p, ".s_adr"}, sadr, eadr);
    chk({p, ".s_dat"}, sdat, edat);
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_owner[d] = -1; m_last[d] = N - 1; m_cnt[d] = 0;
      end else if (m_owner[d] < 0) begin
        m_owner[d] = pick(d, m_cyc);
        if (m_owner[d] >= 0) m_last[d] = m_owner[d];
        m_cnt[d] = 0;
      end else if (timeout_fires(d) || (!m_cyc[m_owner[d]] && !s_ack)) begin
        m_owner[d] = -1; m_cnt[d] = 0;
      end else if (s_ack) begin
        m_cnt[d] = 0;
      end else if (m_stb[m_owner[d]]) begin
        m_cnt[d]++;
      end
    end
  endtask

  // One bus cycle: drive at the falling edge, check 1 ns later, then
  // advance the model to what the next rising edge should produce.
  task automatic drive(input logic r, input logic [3:0] cyc, input logic [3:0] stb, input logic ack);
    @(negedge clk);
    rst = r; m_cyc = cyc; m_stb = stb; s_ack = ack;
    #1;
    check_one(0, rr_grant, rr_ack, rr_err, rr_int, rr_scyc, rr_sstb, rr_swe, rr_ssel, rr_sadr, rr_sdat, rr_mdat);
    check_one(1, fp_grant, fp_ack, fp_err, fp_int, fp_scyc, fp_sstb, fp_swe, fp_ssel, fp_sadr, fp_sdat, fp_mdat);
    model_step();
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] cyc;
    logic       ack;
    logic [3:0] g_rr;
    logic [3:0] g_fp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [3:0] cyc, input logic ack,
                     input logic [3:0] grr, input logic [3:0] gfp);
    vec_t v;
    v.rst = r; v.cyc = cyc; v.ack = ack; v.g_rr = grr; v.g_fp = gfp;
    tbl.push_back(v);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1; m_last[d] = N - 1; m_cnt[d] = 0;
    end
    for (int k = 0; k < N; k++) begin
      m_adr[k*32 +: 32] = 32'hA000_0000 + 32'(k) * 32'h100;
      m_dat[k*32 +: 32] = 32'hD000_0000 + 32'(k);
      m_sel[k*4 +: 4]   = 4'(k + 1);
    end
    m_we  = 4'b0101;
    s_dat = 32'h5A5A_0001;
    s_int = 1'b1;

    // rst, cyc (stb follows cyc), ack, expected grant rr, expected grant fp
    add(1, 4'b1111, 1, 4'b0000, 4'b0000);   // reset state with busy inputs
    add(1, 4'b1111, 1, 4'b0000, 4'b0000);
    add(0, 4'b1010, 0, 4'b0000, 4'b0000);   // 1010 from IDLE
    add(0, 4'b1010, 1, 4'b0010, 4'b0010);   // master 1 owns, acked
    add(0, 4'b1000, 0, 4'b0010, 4'b0010);   // owner drops cyc
    add(0, 4'b1000, 0, 4'b0000, 4'b0000);   // mandatory idle
    add(0, 4'b1000, 1, 4'b1000, 4'b1000);
    add(0, 4'b0000, 0, 4'b1000, 4'b1000);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000);
    add(0, 4'b1111, 0, 4'b0000, 4'b0000);   // all request: rr order 0,1,2,3,0
    add(0, 4'b1111, 1, 4'b0001, 4'b0001);
    add(0, 4'b1110, 0, 4'b0001, 4'b0001);
    add(0, 4'b1111, 0, 4'b0000, 4'b0000);
    add(0, 4'b1111, 1, 4'b0010, 4'b0001);
    add(0, 4'b1101, 0, 4'b0010, 4'b0001);
    add(0, 4'b1111, 0, 4'b0000, 4'b0001);
    add(0, 4'b1111, 1, 4'b0100, 4'b0001);   // owner 2 acked
    add(0, 4'b1011, 0, 4'b0100, 4'b0001);   // owner 2 drops cyc
    add(0, 4'b1111, 0, 4'b0000, 4'b0001);   // idle, slave cyc low
    add(0, 4'b1111, 1, 4'b1000, 4'b0001);
    add(0, 4'b0111, 0, 4'b1000, 4'b0001);
    add(0, 4'b1111, 0, 4'b0000, 4'b0001);
    add(0, 4'b1111, 1, 4'b0001, 4'b0001);
    add(0, 4'b0000, 0, 4'b0001, 4'b0001);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000);
    add(0, 4'b0100, 0, 4'b0000, 4'b0000);
    add(1, 4'b0100, 0, 4'b0100, 4'b0100);   // reset mid-grant
    add(0, 4'b1111, 0, 4'b0000, 4'b0000);   // dropped; master 0 wins next
    add(0, 4'b1111, 1, 4'b0001, 4'b0001);
    add(0, 4'b0000, 0, 4'b0001, 4'b0001);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].cyc, tbl[i].cyc, tbl[i].ack);
      chk($sformatf("tbl%0d.rr_grant", i), 32'(rr_grant), 32'(tbl[i].g_rr));
      chk($sformatf("tbl%0d.fp_grant", i), 32'(fp_grant), 32'(tbl[i].g_fp));
      chk($sformatf("tbl%0d.rr_ack", i), 32'(rr_ack), 32'(tbl[i].ack ? tbl[i].g_rr : 4'b0000));
      chk($sformatf("tbl%0d.rr_scyc", i), 32'(rr_scyc), 32'(|(tbl[i].cyc & tbl[i].g_rr)));
      chk($sformatf("tbl%0d.fp_scyc", i), 32'(fp_scyc), 32'(|(tbl[i].cyc & tbl[i].g_fp)));
    end

    // Master 3 strobes into a slave that never acks.
    drive(0, 4'b1000, 4'b1000, 0);
    for (int i = 1; i <= 10; i++) begin
      logic [3:0] eg, ee;
      drive(0, 4'b1000, 4'b1000, 0);
      ee = (TO_EN && i == TIMEOUT_P) ? 4'b1000 : 4'b0000;
      eg = (TO_EN && i == TIMEOUT_P + 1) ? 4'b0000 : 4'b1000;
      chk($sformatf("stall%0d.rr_err", i), 32'(rr_err), 32'(ee));
      chk($sformatf("stall%0d.rr_grant", i), 32'(rr_grant), 32'(eg));
    end
    drive(0, 4'b0000, 4'b0000, 0);
    drive(0, 4'b0000, 4'b0000, 0);

    for (int c = 0; c < 3000; c++) begin
      logic [3:0] cyc, stb;
      cyc = 4'($urandom);
      stb = cyc & 4'($urandom | $urandom);
      m_we  = 4'($urandom);
      m_sel = 16'($urandom);
      m_adr = {$urandom, $urandom, $urandom, $urandom};
      m_dat = {$urandom, $urandom, $urandom, $urandom};
      s_dat = $urandom;
      s_int = 1'($urandom);
      drive(($urandom_range(0, 63) == 0), cyc, stb, ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
